// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared constants for the bit-serial adder: FSM state encodings and the
//   helper that sizes the bit counter from the operand width.
package serial_adder_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter width for a WIDTH-bit operation (counts 0..WIDTH-1).
  // Never smaller than one bit.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder
//   Single-bit full adder cell.
// Ports:
//   a, b : addend bits
//   c    : carry in
//   s    : sum bit
//   c0   : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic c0
);

  assign s  = a ^ b ^ c;
  assign c0 = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial, LSB-first adder of two WIDTH-bit operands. One bit is added
//   per cycle through a single full_adder with a registered carry, giving
//   WIDTH cycles of busy followed by a one-cycle done pulse.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   start    : sample a_in/b_in/cin (honoured in IDLE or DONE only)
//   a_in     : operand A
//   b_in     : operand B
//   cin      : carry into bit 0
//   busy     : high while bits are processed
//   done     : one-cycle pulse, results valid from this cycle on
//   sum_out  : (a_in + b_in + cin) mod 2^WIDTH, held until next completion
//   cout_out : carry out of bit WIDTH-1, held with sum_out
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out
);

  localparam int CW = cnt_w(WIDTH);

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, result_reg;
  logic             carry_reg;
  logic [CW-1:0]    count_reg;
  logic             fa_s, fa_c0;
  logic             last_bit;
  logic             load;

  full_adder u_fa (
    .a  (a_sh_reg[0]),
    .b  (b_sh_reg[0]),
    .c  (carry_reg),
    .s  (fa_s),
    .c0 (fa_c0)
  );

  assign last_bit = (count_reg == CW'(WIDTH - 1));
  // A new operation may begin from IDLE or straight out of DONE.
  assign load     = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start)    state_next = ST_RUN;
      ST_RUN:  if (last_bit) state_next = ST_DONE;
      ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; RUN and DONE are exclusive so busy/done are too.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand shifters, carry, counter, partial result and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      result_reg <= '0;
      carry_reg  <= 1'b0;
      count_reg  <= '0;
      sum_out    <= '0;
      cout_out   <= 1'b0;
    end else if (load) begin
      a_sh_reg   <= a_in;
      b_sh_reg   <= b_in;
      carry_reg  <= cin;
      count_reg  <= '0;
      result_reg <= '0;
    end else if (state_reg == ST_RUN) begin
      carry_reg  <= fa_c0;
      result_reg <= {fa_s, result_reg[WIDTH-1:1]};
      a_sh_reg   <= a_sh_reg >> 1;
      b_sh_reg   <= b_sh_reg >> 1;
      count_reg  <= count_reg + CW'(1);
      // The final sum bit is still combinational here, so the published
      // result is assembled from it rather than from result_reg.
      if (last_bit) begin
        sum_out  <= {fa_s, result_reg[WIDTH-1:1]};
        cout_out <= fa_c0;
      end
    end
  end

endmodule
